// File: rtl/fft_wn_seq.sv
// Twiddle-factor sequencer for a radix-2 FFT stage: streams W^k for every butterfly j
// of the requested stage over a valid/ready handshake, from a quarter-wave cosine table.
module fft_wn_seq #(
  parameter int FFT_LEN = 64,
  parameter int WN_WID  = 10,
  parameter int STG_WID = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [STG_WID-1:0]         stage_i,
  input  logic                       inv_i,
  input  logic                       abort_i,
  input  logic                       wn_ready_i,
  output logic                       wn_valid_o,
  output logic signed [WN_WID-1:0]   wn_re_o,
  output logic signed [WN_WID-1:0]   wn_im_o,
  output logic [$clog2(FFT_LEN)-2:0] wn_idx_o,
  output logic                       wn_last_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int LOG2 = $clog2(FFT_LEN);
  localparam int IW   = LOG2 - 1;
  localparam int QN   = FFT_LEN / 4;

  typedef enum logic {IDLE, RUN} state_t;

  // Elaboration-time rounding of the scaled cosine; the argument stays in the first quadrant.
  function automatic logic signed [WN_WID-1:0] cos_entry(input int m);
    real x;
    x = (2.0 ** (WN_WID - 2)) * $cos(2.0 * 3.14159265358979 * real'(m) / real'(FFT_LEN));
    return WN_WID'($rtoi(x + 0.5));
  endfunction

  logic signed [WN_WID-1:0] cos_rom [0:QN];

  for (genvar m = 0; m <= QN; m++) begin : g_rom
    assign cos_rom[m] = cos_entry(m);
  end

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, j_nxt;
  logic [STG_WID-1:0]       stage_q, s_nxt;
  logic                     inv_q, inv_nxt;
  logic                     last_q, last_d;
  logic                     err_q, err_d;
  logic                     load;
  logic signed [WN_WID-1:0] re_q, im_q, re_c, im_c;
  logic                     stage_ok;

  assign stage_ok = int'(stage_i) < LOG2;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    j_nxt   = idx_q;
    s_nxt   = stage_q;
    inv_nxt = inv_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (stage_ok) begin
            state_d = RUN;
            load    = 1'b1;
            j_nxt   = '0;
            s_nxt   = stage_i;
            inv_nxt = inv_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over a handshake in the same cycle.
        if (abort_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (wn_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            load  = 1'b1;
            j_nxt = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) last_d = &j_nxt;
  end

  // Twiddle for the index about to be presented, so the output registers load it directly.
  always_comb begin
    logic [IW-1:0]   mask;
    logic [IW-1:0]   jm;
    logic [LOG2-1:0] k;
    logic [IW-1:0]   ia;
    logic [IW-1:0]   ib;
    mask = IW'((32'd1 << s_nxt) - 32'd1);
    jm   = j_nxt & mask;
    k    = {1'b0, jm} << (IW - int'(s_nxt));
    if (int'(k) <= QN) begin
      ia   = IW'(k);
      ib   = IW'(QN - int'(k));
      re_c = cos_rom[ia];
      im_c = -cos_rom[ib];
    end else begin
      ia   = IW'(FFT_LEN / 2 - int'(k));
      ib   = IW'(int'(k) - QN);
      re_c = -cos_rom[ia];
      im_c = -cos_rom[ib];
    end
    if (inv_nxt) im_c = -im_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
      if (load) begin
        idx_q   <= j_nxt;
        stage_q <= s_nxt;
        inv_q   <= inv_nxt;
        re_q    <= re_c;
        im_q    <= im_c;
      end
    end
  end

  assign wn_valid_o = (state_q == RUN);
  assign busy_o     = (state_q == RUN);
  assign wn_re_o    = re_q;
  assign wn_im_o    = im_q;
  assign wn_idx_o   = idx_q;
  assign wn_last_o  = last_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fft_wn_seq.sv
// Scoreboard bench for fft_wn_seq at FFT_LEN=64: expected beats come from a hand-rounded
// quarter-wave table; a negedge monitor pops and compares every handshake.
module tb_fft_wn_seq;

  localparam int N  = 64;
  localparam int WW = 10;
  localparam int SW = 3;
  localparam int IW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start_i = 1'b0;
  logic [SW-1:0]        stage_i = '0;
  logic                 inv_i = 1'b0;
  logic                 abort_i = 1'b0;
  logic                 wn_ready_i = 1'b1;
  logic                 wn_valid_o;
  logic signed [WW-1:0] wn_re_o;
  logic signed [WW-1:0] wn_im_o;
  logic [IW-1:0]        wn_idx_o;
  logic                 wn_last_o;
  logic                 busy_o;
  logic                 err_o;

  typedef struct {
    int idx;
    int re;
    int im;
    int last;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // round(256*cos(2*pi*m/64)), m = 0..16
  int ctab [0:16] = '{256, 255, 251, 245, 237, 226, 213, 198, 181,
                      162, 142, 121, 98, 74, 50, 25, 0};

  fft_wn_seq #(.FFT_LEN(N), .WN_WID(WW), .STG_WID(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stage_i(stage_i), .inv_i(inv_i),
    .abort_i(abort_i), .wn_ready_i(wn_ready_i), .wn_valid_o(wn_valid_o),
    .wn_re_o(wn_re_o), .wn_im_o(wn_im_o), .wn_idx_o(wn_idx_o), .wn_last_o(wn_last_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_seq(input int s, input bit inv);
    beat_t b;
    int    k;
    for (int j = 0; j < N / 2; j++) begin
      k = (j % (1 << s)) * ((N / 2) >> s);
      if (k <= 16) begin
        b.re = ctab[k];
        b.im = -ctab[16 - k];
      end else begin
        b.re = -ctab[32 - k];
        b.im = -ctab[k - 16];
      end
      if (inv) b.im = -b.im;
      b.idx  = j;
      b.last = (j == N / 2 - 1) ? 1 : 0;
      sb.push_back(b);
    end
  endfunction

  // Monitor: compares each handshake against the queue and checks outputs hold while stalled.
  logic stalled = 1'b0;
  int   held = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check_output("hold_stable", int'({wn_valid_o, wn_idx_o, wn_re_o, wn_im_o, wn_last_o}), held);
      stalled = wn_valid_o && !wn_ready_i;
      if (stalled) held = int'({wn_valid_o, wn_idx_o, wn_re_o, wn_im_o, wn_last_o});
      if (wn_valid_o && wn_ready_i) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL unexpected_beat: got idx %0d, expected no beat", wn_idx_o);
        end else begin
          e = sb.pop_front();
          if (int'(wn_idx_o) != e.idx || int'(wn_re_o) != e.re || int'(wn_im_o) != e.im ||
              int'(wn_last_o) != e.last) begin
            n_bad++;
            $display("[TB] FAIL beat: got idx %0d (%0d,%0d) last %0d, expected idx %0d (%0d,%0d) last %0d",
                     wn_idx_o, wn_re_o, wn_im_o, wn_last_o, e.idx, e.re, e.im, e.last);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input int s, input bit inv);
    push_seq(s, inv);
    @(posedge clk); #1;
    start_i = 1'b1;
    stage_i = SW'(s);
    inv_i   = inv;
    @(posedge clk); #1;
    start_i = 1'b0;
    inv_i   = 1'b0;
    check_output("busy_after_start", int'(busy_o), 1);
  endtask

  task automatic wait_idx(input int j);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(wn_valid_o && int'(wn_idx_o) == j) && n < 100);
    if (n >= 100) check_output("wait_idx_timeout", n, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() > 0) check_output("drain_remaining", sb.size(), 0);
    sb.delete();
    check_output("busy_during_last", int'(busy_o), 1);
    @(posedge clk); #1;
    check_output("busy_after_last", int'(busy_o), 0);
    check_output("valid_after_last", int'(wn_valid_o), 0);
    check_output("last_after_last", int'(wn_last_o), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_valid"}, int'(wn_valid_o), 0);
    check_output({tag, "_busy"}, int'(busy_o), 0);
    check_output({tag, "_last"}, int'(wn_last_o), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_idle_zero("reset");
    check_output("reset_err", int'(err_o), 0);
    check_output("reset_re", int'(wn_re_o), 0);
    check_output("reset_im", int'(wn_im_o), 0);
    check_output("reset_idx", int'(wn_idx_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    apply_stimulus(0, 1'b0);
    wait_drain();
    apply_stimulus(5, 1'b0);
    wait_drain();
    apply_stimulus(1, 1'b0);
    wait_drain();
    apply_stimulus(5, 1'b1);
    wait_drain();
    apply_stimulus(3, 1'b0);
    wait_drain();

    apply_stimulus(5, 1'b0);
    wait_idx(7);
    check_output("stall_j7_re", int'(wn_re_o), 198);
    check_output("stall_j7_im", int'(wn_im_o), -162);
    wn_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 wn_ready_i = 1'b1;
    wait_drain();

    for (int s = 6; s <= 7; s++) begin
      @(posedge clk); #1;
      start_i = 1'b1;
      stage_i = SW'(s);
      @(posedge clk); #1;
      start_i = 1'b0;
      check_output("bad_start_err", int'(err_o), 1);
      check_idle_zero("bad_start");
      @(posedge clk); #1;
      check_output("bad_start_err_pulse", int'(err_o), 0);
      check_idle_zero("bad_start_after");
    end

    apply_stimulus(5, 1'b0);
    wait_idx(12);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check_idle_zero("midreset");
    check_output("midreset_idx", int'(wn_idx_o), 0);
    check_output("midreset_re", int'(wn_re_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(5, 1'b0);
    wait_drain();

    apply_stimulus(5, 1'b0);
    wait_idx(20);
    abort_i = 1'b1;
    start_i = 1'b1;
    stage_i = SW'(5);
    @(posedge clk); #1;
    abort_i = 1'b0;
    start_i = 1'b0;
    sb.delete();
    check_idle_zero("abort");
    check_output("abort_err", int'(err_o), 0);
    @(posedge clk); #1;
    check_idle_zero("abort_start_ignored");
    apply_stimulus(5, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
